adpll_lock_mod_ctrl: RTL and testbench
======================================

ADPLL_LOCK_MOD_CTRL -- requirements
Module: adpll_lock_mod_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (all logic on posedge) and rst.
REQ-002 Parameter CNT_W, default 20: width of the settling counter and of the timeout value.
REQ-003 Parameter SYM_W, default 5: width of the symbol-period value.
REQ-004 Parameter LFSR_SEED, default 16'hACE1: 16-bit PRBS seed; a value of 0 SHALL be replaced by 16'h0001.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- en  in  1  ADPLL enable
- channel_lock  in  1  lock indication from the loop
- mode  in  2  operation mode: PD=0, TEST=1, RX=2, TX=3
- sym_period  in  SYM_W  symbol length in cycles, minus 1
- timeout  in  CNT_W  settle limit in cycles; 0 disables the timeout
- data_mod  out  1  modulation bit
- data_valid  out  1  one-cycle pulse when data_mod updates
- settle_cycles  out  CNT_W  measured settling time in cycles
- settle_done  out  1  settling time measured
- timeout_err  out  1  lock not reached within timeout
- state  out  2  FSM state: IDLE=0, SETTLE=1, LOCKED=2, FAIL=3

Function
REQ-006 en SHALL be registered to en_d; a rising edge SHALL be detected as en & ~en_d.
REQ-007 IDLE -> SETTLE on an en rising edge. On entry: settle counter = 1, settle_done = 0, timeout_err = 0, LFSR reloaded with the seed.
REQ-008 In SETTLE, the counter SHALL increment by 1 each cycle and saturate at all-ones.
REQ-009 In SETTLE, channel_lock = 1 SHALL latch the current counter value into settle_cycles, set settle_done = 1 and move to LOCKED on the next cycle.
REQ-010 In SETTLE, if timeout != 0, counter == timeout and channel_lock = 0, the block SHALL set timeout_err = 1 and move to FAIL.
REQ-011 If lock and the timeout condition occur in the same cycle, lock SHALL win.
REQ-012 On entry to LOCKED, sym_cnt SHALL be cleared to 0.
REQ-013 In LOCKED with mode == TX:
- sym_cnt SHALL increment each cycle.
- When sym_cnt == sym_period: sym_cnt <= 0, LFSR advances one step, data_mod <= new LFSR bit 0, data_valid = 1 for that single cycle.
REQ-014 The first data_valid SHALL occur sym_period+1 cycles after the first LOCKED cycle. sym_period = 0 SHALL give a data_valid pulse every cycle.
REQ-015 In LOCKED with mode != TX, sym_cnt, LFSR and data_mod SHALL hold, and data_valid = 0.
REQ-016 The LFSR SHALL be a Fibonacci LFSR x^16+x^14+x^13+x^11+1: shift right, feedback bit0^bit2^bit3^bit5 into bit 15.
REQ-017 In LOCKED, channel_lock = 0 SHALL cause:
- move to SETTLE;
- counter = 1, settle_done = 0;
- data_mod = 0, data_valid = 0;
- LFSR reloaded with the seed;
- settle_cycles retains its last value.
REQ-018 FAIL SHALL be left only via en = 0.
REQ-019 en = 0 in any state SHALL move to IDLE on the next cycle, with data_mod = 0 and data_valid = 0. settle_cycles, settle_done and timeout_err SHALL hold until the next en rising edge.
REQ-020 If en stays high in IDLE with no rising edge, which happens after reset, the block SHALL remain in IDLE.
REQ-021 data_mod, data_valid, settle_done, timeout_err and state SHALL be registered outputs.

Reset
REQ-022 Reset SHALL have priority over all other inputs.
REQ-023 On rst = 1, values SHALL be:
- state = IDLE
- en_d = 0
- settle counter = 0, settle_cycles = 0
- settle_done = 0, timeout_err = 0
- sym_cnt = 0
- data_mod = 0, data_valid = 0
- LFSR = seed
REQ-024 Reset asserted mid-operation SHALL abort any measurement or symbol in progress, and all outputs SHALL take their reset values on the next edge.

Verification
REQ-025 Settle measurement: en 0->1, channel_lock rises in the 100th SETTLE cycle, timeout = 0 -> settle_cycles = 100, settle_done = 1, state = LOCKED.
REQ-026 Timeout: timeout = 50, lock never asserted -> timeout_err = 1 and state = FAIL after the 50th SETTLE cycle. Then en = 0 -> IDLE. Then en 0->1 -> timeout_err cleared.
REQ-027 Lock/timeout tie: timeout = 10, lock rises in SETTLE cycle 10 -> LOCKED, settle_cycles = 10, timeout_err = 0.
REQ-028 TX symbols: mode = TX, sym_period = 31, locked -> data_valid every 32 cycles. The data_mod sequence SHALL equal LFSR bit 0 of successive steps from seed 16'hACE1, with the first pulse 32 cycles after LOCKED entry.
REQ-029 Lock loss and mode: channel_lock drops while in TX -> SETTLE, data_mod = 0, settle_done = 0. After relock, the data sequence SHALL restart from the seed. mode = RX while locked -> no data_valid and data_mod held.
REQ-030 Reset mid-TX: rst pulsed for 1 cycle in LOCKED -> all outputs at reset values and state = IDLE. With en held high, state SHALL remain IDLE.

Source files
------------

// File: rtl/adpll_lock_mod_ctrl.sv
// rtl/adpll_lock_mod_ctrl.sv - ADPLL settle-time measurement, lock supervision and PRBS TX modulation
module adpll_lock_mod_ctrl #(
  parameter int          CNT_W     = 20,
  parameter int          SYM_W     = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             channel_lock,
  input  logic [1:0]       mode,
  input  logic [SYM_W-1:0] sym_period,
  input  logic [CNT_W-1:0] timeout,
  output logic             data_mod,
  output logic             data_valid,
  output logic [CNT_W-1:0] settle_cycles,
  output logic             settle_done,
  output logic             timeout_err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_LOCKED = 2'd2, S_FAIL = 2'd3} state_t;

  localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [1:0]  MODE_TX = 2'd3;

  state_t           state_q;
  logic             en_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] settle_cycles_q;
  logic             settle_done_q;
  logic             timeout_err_q;
  logic             data_mod_q;
  logic             data_valid_q;
  logic [SYM_W-1:0] sym_cnt_q;
  logic [15:0]      lfsr_q;

  logic             en_rise;
  logic             lfsr_fb;
  logic [15:0]      lfsr_next;

  // armed_q blocks the spurious edge seen when en is already high as reset releases
  assign en_rise   = en & ~en_q & armed_q;
  assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign lfsr_next = {lfsr_fb, lfsr_q[15:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      en_q            <= 1'b0;
      armed_q         <= 1'b0;
      cnt_q           <= '0;
      settle_cycles_q <= '0;
      settle_done_q   <= 1'b0;
      timeout_err_q   <= 1'b0;
      sym_cnt_q       <= '0;
      data_mod_q      <= 1'b0;
      data_valid_q    <= 1'b0;
      lfsr_q          <= SEED;
    end else begin
      en_q         <= en;
      armed_q      <= armed_q | ~en;
      data_valid_q <= 1'b0;
      if (!en) begin
        state_q    <= S_IDLE;
        data_mod_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (en_rise) begin
              state_q       <= S_SETTLE;
              cnt_q         <= CNT_W'(1);
              settle_done_q <= 1'b0;
              timeout_err_q <= 1'b0;
              lfsr_q        <= SEED;
            end
          end
          S_SETTLE: begin
            // lock is checked first so it wins a tie with the timeout
            if (channel_lock) begin
              settle_cycles_q <= cnt_q;
              settle_done_q   <= 1'b1;
              sym_cnt_q       <= '0;
              state_q         <= S_LOCKED;
            end else if ((timeout != '0) && (cnt_q == timeout)) begin
              timeout_err_q <= 1'b1;
              state_q       <= S_FAIL;
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_LOCKED: begin
            if (!channel_lock) begin
              state_q       <= S_SETTLE;
              cnt_q         <= CNT_W'(1);
              settle_done_q <= 1'b0;
              data_mod_q    <= 1'b0;
              lfsr_q        <= SEED;
            end else if (mode == MODE_TX) begin
              if (sym_cnt_q == sym_period) begin
                sym_cnt_q    <= '0;
                lfsr_q       <= lfsr_next;
                data_mod_q   <= lfsr_next[0];
                data_valid_q <= 1'b1;
              end else begin
                sym_cnt_q <= sym_cnt_q + SYM_W'(1);
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign state         = state_q;
  assign data_mod      = data_mod_q;
  assign data_valid    = data_valid_q;
  assign settle_cycles = settle_cycles_q;
  assign settle_done   = settle_done_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_adpll_lock_mod_ctrl.sv
// tb/tb_adpll_lock_mod_ctrl.sv - self-checking bench for adpll_lock_mod_ctrl
module tb_adpll_lock_mod_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, channel_lock;
  logic [1:0]  mode;
  logic [4:0]  sym_period;
  logic [19:0] timeout;
  logic        data_mod, data_valid, settle_done, timeout_err;
  logic [19:0] settle_cycles;
  logic [1:0]  state;

  always #5 clk = ~clk;

  adpll_lock_mod_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .channel_lock(channel_lock), .mode(mode),
    .sym_period(sym_period), .timeout(timeout), .data_mod(data_mod),
    .data_valid(data_valid), .settle_cycles(settle_cycles), .settle_done(settle_done),
    .timeout_err(timeout_err), .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // seq[k] = bit 0 of the PRBS register after k steps from the seed
  bit seq [0:16383];
  localparam int AGE_MAX = (1 << 20) - 1;

  int m_state, m_age, m_sc, m_tx, m_sym;
  bit m_en_prev, m_armed, m_sd, m_te, m_dm, m_dv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a settle "age", a count of TX cycles since lock and a symbol index into seq[]
  task automatic model_update();
    bit rise;
    if (rst) begin
      m_state = 0; m_en_prev = 0; m_armed = 0; m_age = 0; m_sc = 0; m_sd = 0;
      m_te = 0; m_tx = 0; m_sym = 0; m_dm = 0; m_dv = 0;
      return;
    end
    rise = en && !m_en_prev && m_armed;
    m_en_prev = en;
    if (!en) m_armed = 1;
    m_dv = 0;
    if (!en) begin
      m_state = 0;
      m_dm = 0;
    end else begin
      case (m_state)
        0: if (rise) begin m_state = 1; m_age = 1; m_sd = 0; m_te = 0; m_sym = 0; end
        1: begin
          if (channel_lock) begin m_sc = m_age; m_sd = 1; m_tx = 0; m_state = 2; end
          else if (timeout != 0 && m_age == int'(timeout)) begin m_te = 1; m_state = 3; end
          else if (m_age < AGE_MAX) m_age++;
        end
        2: begin
          if (!channel_lock) begin m_state = 1; m_age = 1; m_sd = 0; m_dm = 0; m_sym = 0; end
          else if (mode == 2'd3) begin
            m_tx++;
            if (m_tx % (int'(sym_period) + 1) == 0) begin
              m_sym++;
              m_dm = seq[m_sym % 16384];
              m_dv = 1;
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("model_state", state, m_state);
    chk("model_data_valid", data_valid, m_dv);
    chk("model_data_mod", data_mod, m_dm);
    chk("model_settle_done", settle_done, m_sd);
    chk("model_timeout_err", timeout_err, m_te);
    chk("model_settle_cycles", settle_cycles, m_sc);
  endtask

  typedef struct {
    bit rst, en, lock;
    int exp_state;
    bit exp_sd, exp_te;
    int exp_sc;
  } vec_t;
  vec_t tbl [18];

  initial begin
    logic [15:0] l;
    bit held_dm;
    l = 16'hACE1;
    seq[0] = l[0];
    for (int k = 1; k < 16384; k++) begin
      l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
      seq[k] = l[0];
    end

    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 3, 0, 1, 0};
    tbl[8]  = '{0, 1, 0, 3, 0, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 0};
    tbl[10] = '{0, 1, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 2, 1, 0, 1};
    tbl[12] = '{0, 1, 1, 2, 1, 0, 1};
    tbl[13] = '{0, 1, 0, 1, 0, 0, 1};
    tbl[14] = '{0, 1, 0, 1, 0, 0, 1};
    tbl[15] = '{0, 1, 1, 2, 1, 0, 2};
    tbl[16] = '{1, 1, 1, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 1, 0, 0, 0, 0};

    rst = 1; en = 1; channel_lock = 0; mode = 2'd2; sym_period = 0; timeout = 20'd3;
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; channel_lock = tbl[i].lock;
      step();
      chk($sformatf("tbl%0d_state", i), state, tbl[i].exp_state);
      chk($sformatf("tbl%0d_settle_done", i), settle_done, tbl[i].exp_sd);
      chk($sformatf("tbl%0d_timeout_err", i), timeout_err, tbl[i].exp_te);
      chk($sformatf("tbl%0d_settle_cycles", i), settle_cycles, tbl[i].exp_sc);
      chk($sformatf("tbl%0d_data_valid", i), data_valid, 0);
    end

    // settle measurement of 100 cycles, then TX symbols with period 32
    rst = 0; en = 0; channel_lock = 0; timeout = 0; mode = 2'd3; sym_period = 5'd31;
    step();
    en = 1; step();
    for (int i = 0; i < 99; i++) step();
    channel_lock = 1; step();
    chk("settle100_cycles", settle_cycles, 100);
    chk("settle100_done", settle_done, 1);
    chk("settle100_state", state, 2);
    for (int k = 1; k <= 128; k++) begin
      step();
      chk($sformatf("tx_dv_t%0d", k), data_valid, (k % 32) == 0);
      if (k % 32 == 0) chk($sformatf("tx_dm_sym%0d", k / 32), data_mod, seq[k / 32]);
    end

    // lock loss, relock restarts the PRBS, then RX holds
    channel_lock = 0; step();
    chk("loss_state", state, 1);
    chk("loss_dm", data_mod, 0);
    chk("loss_done", settle_done, 0);
    chk("loss_keep_cycles", settle_cycles, 100);
    channel_lock = 1; step();
    for (int k = 1; k <= 32; k++) step();
    chk("relock_dv", data_valid, 1);
    chk("relock_dm", data_mod, seq[1]);
    mode = 2'd2;
    held_dm = data_mod;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("rx_no_dv", data_valid, 0);
      chk("rx_dm_hold", data_mod, held_dm);
    end

    // reset mid-TX with en held high
    mode = 2'd3; rst = 1; step();
    chk("rst_state", state, 0);
    chk("rst_sc", settle_cycles, 0);
    chk("rst_done", settle_done, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_dm", data_mod, 0);
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rst_en_high_idle", state, 0);
    end

    // lock/timeout tie in cycle 10
    en = 0; channel_lock = 0; timeout = 20'd10; step();
    en = 1; step();
    for (int i = 0; i < 9; i++) step();
    channel_lock = 1; step();
    chk("tie_state", state, 2);
    chk("tie_sc", settle_cycles, 10);
    chk("tie_err", timeout_err, 0);

    // timeout at 50, en low to IDLE, rising edge clears the error
    en = 0; channel_lock = 0; timeout = 20'd50; step();
    en = 1; step();
    for (int i = 0; i < 49; i++) begin
      step();
      chk("to_still_settle", state, 1);
    end
    step();
    chk("to_state_fail", state, 3);
    chk("to_err", timeout_err, 1);
    en = 0; step();
    chk("to_idle", state, 0);
    chk("to_err_held", timeout_err, 1);
    en = 1; step();
    chk("to_err_cleared", timeout_err, 0);
    chk("to_resettle", state, 1);

    // sym_period 0: a pulse every locked TX cycle
    en = 0; timeout = 0; sym_period = 0; step();
    en = 1; step();
    channel_lock = 1; step();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("p0_dv", data_valid, 1);
      chk("p0_dm", data_mod, seq[k]);
    end

    // randomized run against the model
    en = 0; step();
    sym_period = 5'($urandom_range(0, 7));
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom % 500) == 0;
      if ($urandom % 100 == 0) en = ~en;
      if ($urandom % 40 == 0) channel_lock = ~channel_lock;
      if ($urandom % 60 == 0) mode = 2'($urandom);
      if (!en && ($urandom % 4 == 0)) begin
        timeout = ($urandom % 3 == 0) ? 20'd0 : 20'($urandom_range(1, 60));
        sym_period = 5'($urandom_range(0, 7));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
